mc_ctrl_fsm: RTL and testbench
==============================

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 opcode  in  7  instr[6:0] from the instruction register; stable outside FETCH.
REQ-005 zero  in  1  ALU zero flag, used in state BEQ.
REQ-006 mem_ready  in  1  memory handshake; access completes in any cycle where it is 1.
REQ-007 pc_write  out  1  PC load enable; equals pc_update | (branch & zero).
REQ-008 adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 mem_write  out  1  data memory write request.
REQ-010 ir_write  out  1  instruction register load enable.
REQ-011 result_src  out  2  result mux select: 00 = ALUOut, 01 = read data, 10 = ALU result.
REQ-012 alu_src_a  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
REQ-013 alu_src_b  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-014 alu_op  out  2  op class to ALU decoder: 00 = R-type, 10 = I-type ALU, 01 = add, 11 = beq compare.
REQ-015 imm_src  out  2  immediate format, decoded from opcode: 00 = I/lw, 01 = sw, 10 = beq, 11 = jal.
REQ-016 reg_write  out  1  register file write enable.
REQ-017 instr_done  out  1  one-cycle pulse in the last cycle of each instruction.

Function
REQ-018 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, plus ILLEGAL when the macro in REQ-034 is defined.
REQ-019 FETCH SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-020 DECODE SHALL transition by opcode:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1100011 -> BEQ
- 1101111 -> JAL
- any other opcode -> per REQ-034
REQ-021 MEMADR SHALL go to MEMREAD for lw and to MEMWRITE for sw.
REQ-022 MEMREAD SHALL hold until mem_ready=1, then go to MEMWB.
REQ-023 MEMWRITE SHALL hold until mem_ready=1, then go to FETCH.
REQ-024 The remaining transitions SHALL be:
- EXECUTER, EXECUTEI, JAL -> ALUWB
- MEMWB, ALUWB, BEQ -> FETCH
REQ-025 Outputs SHALL take these values per state; any output not listed is 0, and alu_op defaults to 01:
- FETCH: alu_src_a=00, alu_src_b=10, alu_op=01, result_src=10; ir_write=pc_update=mem_ready.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=01.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=01.
- MEMREAD: adr_src=1.
- MEMWRITE: adr_src=1, mem_write=1 (held every cycle until mem_ready=1).
- MEMWB: result_src=01, reg_write=1.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=00.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10.
- ALUWB: result_src=00, reg_write=1.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=11, branch=1.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=01, pc_update=1.
REQ-026 instr_done SHALL be 1 in MEMWB, ALUWB, BEQ, and in MEMWRITE when mem_ready=1; it SHALL be 0 otherwise.
REQ-027 Instruction latency from entering FETCH, with mem_ready tied to 1, SHALL be:
- lw: 5 cycles
- sw, R-type, I-type, jal: 4 cycles
- beq: 3 cycles
REQ-028 Each cycle with mem_ready=0 in a waiting state SHALL add exactly one cycle of latency, with all outputs held constant.
REQ-029 imm_src SHALL be combinational from opcode, independent of state; unknown opcodes SHALL give 00.

Reset
REQ-030 Asserting rst SHALL force the state to FETCH immediately, regardless of clk.
REQ-031 While rst=1, pc_write, ir_write, mem_write, reg_write and instr_done SHALL be 0.
REQ-032 Reset asserted mid-instruction SHALL abort it; no partial register write or memory write SHALL occur after rst rises.
REQ-033 The first FETCH SHALL begin on the first rising clk edge after rst falls.

Configuration
REQ-034 Macro RV32I_CTRL_ILLEGAL_EN controls handling of unknown opcodes in DECODE:
- Defined: the FSM SHALL go to ILLEGAL, assert an extra output illegal_instr (out 1), hold all write enables at 0, and stay in ILLEGAL until rst.
- Undefined: the FSM SHALL return to FETCH as a NOP with instr_done=1 in DECODE; the illegal_instr port and the ILLEGAL state SHALL NOT exist.

Verification
REQ-035 Reset, mem_ready=1, opcode=0110011: state sequence FETCH, DECODE, EXECUTER, ALUWB; alu_op=00 in EXECUTER; reg_write=1 and instr_done=1 in cycle 4.
REQ-036 lw (0000011) with mem_ready=0 for 3 cycles in MEMREAD: MEMREAD lasts 4 cycles with adr_src=1 throughout; MEMWB then gives result_src=01 and reg_write=1; total 8 cycles.
REQ-037 beq (1100011) with zero=1: pc_write=1 in BEQ, instr_done=1, then FETCH. Same with zero=0: pc_write=0.
REQ-038 sw (0100011), mem_ready=0 for 2 cycles: mem_write=1 for 3 consecutive cycles; reg_write never 1.
REQ-039 rst pulsed asynchronously (mid-cycle) during ALUWB: reg_write drops at once; the FSM is in FETCH after release.
REQ-040 opcode=1111111 with RV32I_CTRL_ILLEGAL_EN defined: illegal_instr=1 and the FSM is stuck until rst. Without the macro: FETCH, DECODE, FETCH, with no write enables asserted.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm -- multicycle RV32I control unit (Moore FSM).
//
// Steps one instruction at a time through FETCH/DECODE and a short
// opcode-dependent tail, producing datapath selects and write enables.
// FETCH, MEMREAD and MEMWRITE wait on mem_ready, holding all outputs.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset (state -> FETCH)
//   opcode[6:0]       instr[6:0], stable outside FETCH
//   zero              ALU zero flag, qualifies the branch in BEQ
//   mem_ready         memory handshake, access completes when 1
//   pc_write          PC load enable = pc_update | (branch & zero)
//   adr_src           memory address select (0 PC, 1 ALUOut)
//   mem_write         data memory write request
//   ir_write          instruction register load enable
//   result_src[1:0]   00 ALUOut, 01 read data, 10 ALU result
//   alu_src_a[1:0]    00 PC, 01 old PC, 10 rs1
//   alu_src_b[1:0]    00 rs2, 01 immediate, 10 constant 4
//   alu_op[1:0]       00 R-type, 10 I-type, 01 add, 11 beq compare
//   imm_src[1:0]      immediate format from opcode (combinational)
//   reg_write         register file write enable
//   instr_done        pulse in the last cycle of each instruction
//   illegal_instr     (only with RV32I_CTRL_ILLEGAL_EN) unknown opcode seen
//
// Build option: define RV32I_CTRL_ILLEGAL_EN to trap unknown opcodes in an
// ILLEGAL state that holds until reset. Without it, unknown opcodes
// retire as a NOP straight from DECODE.

module mc_ctrl_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       instr_done
`ifdef RV32I_CTRL_ILLEGAL_EN
  ,
  output logic       illegal_instr
`endif
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
`ifdef RV32I_CTRL_ILLEGAL_EN
    ,
    S_ILLEGAL
`endif
  } state_t;

  state_t state_q, state_d;

  // Ungated enables; the write-type ones are masked by rst below so that
  // nothing can be written while reset is held.
  logic pc_update, branch;
  logic mem_write_raw, ir_write_raw, reg_write_raw, done_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b01;
    pc_update     = 1'b0;
    branch        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    done_raw      = 1'b0;
`ifdef RV32I_CTRL_ILLEGAL_EN
    illegal_instr = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        // IR and PC load only in the cycle the fetch completes.
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
`ifdef RV32I_CTRL_ILLEGAL_EN
            state_d  = S_ILLEGAL;
`else
            // Unknown opcode retires here as a NOP.
            state_d  = S_FETCH;
            done_raw = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        done_raw      = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b00;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
        state_d       = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b11;
        branch    = 1'b1;
        done_raw  = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
`ifdef RV32I_CTRL_ILLEGAL_EN
      S_ILLEGAL: begin
        illegal_instr = 1'b1;
        state_d       = S_ILLEGAL;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  assign pc_write   = ~rst & (pc_update | (branch & zero));
  assign mem_write  = ~rst & mem_write_raw;
  assign ir_write   = ~rst & ir_write_raw;
  assign reg_write  = ~rst & reg_write_raw;
  assign instr_done = ~rst & done_raw;

  // Immediate format depends only on the opcode, not on the state.
  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: each instruction is expanded into a queue of
// expected per-cycle steps derived from the output table; waiting steps
// repeat while mem_ready=0. Directed scenarios add literal checks.
module tb_mc_ctrl_fsm;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
`ifdef RV32I_CTRL_ILLEGAL_EN
  logic       illegal_instr;
`endif

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .reg_write(reg_write), .instr_done(instr_done)
`ifdef RV32I_CTRL_ILLEGAL_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  always #5 clk = ~clk;

  // Bit layout of the observed/expected vector.
  logic [15:0] dut_vec;
  assign dut_vec = {pc_write, adr_src, mem_write, ir_write, result_src,
                    alu_src_a, alu_src_b, alu_op, imm_src, reg_write, instr_done};

  typedef struct packed {
    logic [1:0] a, b, op, rs;
    logic [9:0] f;
  } step_t;

  localparam logic [9:0] M_WAIT  = 10'h001; // repeats while mem_ready=0
  localparam logic [9:0] M_ADR   = 10'h002;
  localparam logic [9:0] M_MW    = 10'h004;
  localparam logic [9:0] M_RW    = 10'h008;
  localparam logic [9:0] M_DONE  = 10'h010;
  localparam logic [9:0] M_BR    = 10'h020;
  localparam logic [9:0] M_PCU   = 10'h040;
  localparam logic [9:0] M_FRDY  = 10'h080; // ir_write/pc_update follow mem_ready
  localparam logic [9:0] M_DRDY  = 10'h100; // instr_done follows mem_ready
  localparam logic [9:0] M_STUCK = 10'h200; // never leaves

  step_t      q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [15:0] obs;
  logic [6:0] next_op = 7'b0110011;

  function automatic step_t st(input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] op, input logic [1:0] rs,
                               input logic [9:0] f);
    step_t s;
    s.a = a; s.b = b; s.op = op; s.rs = rs; s.f = f;
    return s;
  endfunction

  function automatic bit has(input step_t s, input logic [9:0] m);
    return (s.f & m) != 10'h0;
  endfunction

  function automatic logic [1:0] model_imm(input logic [6:0] op);
    case (op)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  task automatic build(input logic [6:0] op);
    step_t dec;
    dec = st(2'b01, 2'b01, 2'b01, 2'b00, 10'h0);
    q.delete();
    q.push_back(st(2'b00, 2'b10, 2'b01, 2'b10, M_WAIT | M_FRDY));
    case (op)
      7'b0000011: begin
        q.push_back(dec);
        q.push_back(st(2'b10, 2'b01, 2'b01, 2'b00, 10'h0));
        q.push_back(st(2'b00, 2'b00, 2'b01, 2'b00, M_WAIT | M_ADR));
        q.push_back(st(2'b00, 2'b00, 2'b01, 2'b01, M_RW | M_DONE));
      end
      7'b0100011: begin
        q.push_back(dec);
        q.push_back(st(2'b10, 2'b01, 2'b01, 2'b00, 10'h0));
        q.push_back(st(2'b00, 2'b00, 2'b01, 2'b00, M_WAIT | M_ADR | M_MW | M_DRDY));
      end
      7'b0110011: begin
        q.push_back(dec);
        q.push_back(st(2'b10, 2'b00, 2'b00, 2'b00, 10'h0));
        q.push_back(st(2'b00, 2'b00, 2'b01, 2'b00, M_RW | M_DONE));
      end
      7'b0010011: begin
        q.push_back(dec);
        q.push_back(st(2'b10, 2'b01, 2'b10, 2'b00, 10'h0));
        q.push_back(st(2'b00, 2'b00, 2'b01, 2'b00, M_RW | M_DONE));
      end
      7'b1100011: begin
        q.push_back(dec);
        q.push_back(st(2'b10, 2'b00, 2'b11, 2'b00, M_BR | M_DONE));
      end
      7'b1101111: begin
        q.push_back(dec);
        q.push_back(st(2'b01, 2'b10, 2'b01, 2'b00, M_PCU));
        q.push_back(st(2'b00, 2'b00, 2'b01, 2'b00, M_RW | M_DONE));
      end
      default: begin
`ifdef RV32I_CTRL_ILLEGAL_EN
        q.push_back(dec);
        q.push_back(st(2'b00, 2'b00, 2'b01, 2'b00, M_STUCK));
`else
        dec.f = M_DONE;
        q.push_back(dec);
`endif
      end
    endcase
  endtask

  function automatic logic [15:0] expect_vec();
    step_t s;
    logic pcu, ir, pcw, mw, rw, dn;
    s   = q[0];
    ir  = has(s, M_FRDY) & mem_ready;
    pcu = has(s, M_PCU) | ir;
    pcw = pcu | (has(s, M_BR) & zero);
    mw  = has(s, M_MW);
    rw  = has(s, M_RW);
    dn  = has(s, M_DONE) | (has(s, M_DRDY) & mem_ready);
    if (rst) begin
      pcw = 1'b0; ir = 1'b0; mw = 1'b0; rw = 1'b0; dn = 1'b0;
    end
    return {pcw, has(s, M_ADR), mw, ir, s.rs, s.a, s.b, s.op,
            model_imm(opcode), rw, dn};
  endfunction

  task automatic compare();
    logic [15:0] e;
    e   = expect_vec();
    obs = dut_vec;
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL cycle%0d outputs: got %b expected %b (opcode %b mem_ready %b rst %b)",
               cyc, obs, e, opcode, mem_ready, rst);
    end
`ifdef RV32I_CTRL_ILLEGAL_EN
    vectors++;
    if (illegal_instr !== has(q[0], M_STUCK)) begin
      miscompares++;
      $display("FAIL cycle%0d illegal_instr: got %b expected %b", cyc,
               illegal_instr, has(q[0], M_STUCK));
    end
`endif
  endtask

  task automatic lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check at negedge, advance the model.
  task automatic tick(input logic r, input logic mr, input logic z);
    rst = r; mem_ready = mr; zero = z;
    if (r) q.delete();
    if (q.size() == 0) begin
      opcode = next_op;
      build(next_op);
    end
    @(negedge clk);
    compare();
    $display("cycle %0d rst=%b op=%b mr=%b z=%b out=%b", cyc, r, opcode, mr, z, obs);
    @(posedge clk);
    cyc++;
    if (r) q.delete();
    else if (!(has(q[0], M_STUCK) || (has(q[0], M_WAIT) && !mr))) void'(q.pop_front());
    #1;
  endtask

  logic [6:0] ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                         7'b0010011, 7'b1100011, 7'b1101111};
  logic [7:0] lw_mr = 8'b11000111; // bit i = mem_ready in tick i
  logic [5:0] sw_mr = 6'b100111;

  initial begin
    int dsum, msum, rsum;
    // Reset with mem_ready high: write enables must stay low.
    tick(1'b1, 1'b1, 1'b0);
    lit("rst_pc_write", int'(obs[15]), 0);
    lit("rst_ir_write", int'(obs[12]), 0);
    tick(1'b1, 1'b1, 1'b0);

    // R-type, no waits: 4 cycles.
    next_op = 7'b0110011;
    tick(1'b0, 1'b1, 1'b0); lit("r_fetch_ir_write", int'(obs[12]), 1);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0); lit("r_exec_alu_op", int'(obs[5:4]), 0);
    tick(1'b0, 1'b1, 1'b0);
    lit("r_wb_reg_write", int'(obs[1]), 1);
    lit("r_wb_done", int'(obs[0]), 1);

    // lw with 3 wait cycles in MEMREAD: 8 cycles total.
    next_op = 7'b0000011; dsum = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, lw_mr[i], 1'($urandom));
      if (i >= 3 && i <= 6) lit("lw_memread_adr_src", int'(obs[14]), 1);
      if (i < 7) dsum += int'(obs[0]);
    end
    lit("lw_memwb_result_src", int'(obs[11:10]), 1);
    lit("lw_memwb_reg_write", int'(obs[1]), 1);
    lit("lw_done_last", int'(obs[0]), 1);
    lit("lw_done_early", dsum, 0);

    // beq taken then not taken.
    next_op = 7'b1100011;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1);
    lit("beq_taken_pc_write", int'(obs[15]), 1);
    lit("beq_done", int'(obs[0]), 1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    lit("beq_not_taken_pc_write", int'(obs[15]), 0);
    next_op = 7'b0110011;
    tick(1'b0, 1'b0, 1'b0);
    lit("beq_then_fetch", int'(obs[7:6]), 2);
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);

    // sw with 2 wait cycles in MEMWRITE.
    next_op = 7'b0100011; msum = 0; rsum = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, sw_mr[i], 1'b0);
      msum += int'(obs[13]);
      rsum += int'(obs[1]);
      if (i >= 3) lit("sw_mem_write_held", int'(obs[13]), 1);
    end
    lit("sw_mem_write_cycles", msum, 3);
    lit("sw_reg_write_never", rsum, 0);

    // Asynchronous reset pulse in the middle of ALUWB.
    next_op = 7'b0010011;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    compare();
    lit("aluwb_reg_write", int'(obs[1]), 1);
    #1 rst = 1'b1;
    #1 lit("async_rst_reg_write", int'(reg_write), 0);
    lit("async_rst_done", int'(instr_done), 0);
    #1 rst = 1'b0; mem_ready = 1'b0;
    #1 lit("after_rst_fetch_b", int'(alu_src_b), 2);
    lit("after_rst_ir_write", int'(ir_write), 0);
    q.delete();
    @(posedge clk);
    cyc++;
    #1;
    next_op = 7'b0110011;
    tick(1'b0, 1'b1, 1'b0);
    lit("after_rst_still_fetch", int'(obs[7:6]), 2);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);

    // Unknown opcode.
    next_op = 7'b1111111;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
`ifdef RV32I_CTRL_ILLEGAL_EN
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      lit("illegal_flag", int'(illegal_instr), 1);
      lit("illegal_writes", int'({obs[15], obs[13], obs[12], obs[1]}), 0);
    end
    next_op = 7'b0110011;
    tick(1'b1, 1'b1, 1'b0);
`else
    lit("nop_decode_done", int'(obs[0]), 1);
    lit("nop_decode_writes", int'({obs[15], obs[13], obs[12], obs[1]}), 0);
    next_op = 7'b0110011;
    tick(1'b0, 1'b0, 1'b0);
    lit("nop_then_fetch", int'(obs[7:6]), 2);
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic with occasional resets and memory stalls.
    for (int n = 0; n < 3000; n++) begin
`ifdef RV32I_CTRL_ILLEGAL_EN
      next_op = ops[$urandom_range(0, 5)];
`else
      if ($urandom_range(0, 7) == 0) next_op = 7'($urandom);
      else next_op = ops[$urandom_range(0, 5)];
`endif
      tick(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
